// File: rtl/alu_mc.sv
// alu_mc: registered single-cycle ALU with an optional multi-cycle shift-add multiplier.
// Build option: define ALU_MC_MUL_EN to enable opcode F as an unsigned WIDTH x WIDTH MUL.
// Without it, opcode F is a NOP, busy and result_hi are tied to 0 and no multiplier exists.
module alu_mc #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       operation,
    input  logic [WIDTH-1:0] lhs_in,
    input  logic [WIDTH-1:0] rhs_in,
    input  logic             assert_bus,
    output logic [WIDTH-1:0] bus_out,
    output logic             bus_en,
    output logic [WIDTH-1:0] result_hi,
    output logic             busy,
    output logic             done,
    output logic             flag_zero,
    output logic             flag_acarry,
    output logic             flag_lcarry,
    output logic             flag_sign,
    output logic             flag_overflow
);

    localparam int unsigned XW = WIDTH + 1;

    localparam logic [3:0] OP_INC = 4'h1;
    localparam logic [3:0] OP_DEC = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_ADC = 4'h4;
    localparam logic [3:0] OP_SHL = 4'h5;
    localparam logic [3:0] OP_SHR = 4'h6;
    localparam logic [3:0] OP_SUB = 4'h7;
    localparam logic [3:0] OP_SBC = 4'h8;
    localparam logic [3:0] OP_XOR = 4'h9;
    localparam logic [3:0] OP_AND = 4'hA;
    localparam logic [3:0] OP_OR  = 4'hB;
    localparam logic [3:0] OP_NOT = 4'hC;
    localparam logic [3:0] OP_ROL = 4'hD;
    localparam logic [3:0] OP_ROR = 4'hE;

    logic [WIDTH-1:0] result;

    logic [XW-1:0]    lhs_x;
    logic [XW-1:0]    rhs_x;
    logic [XW-1:0]    cin_x;
    logic [XW-1:0]    wide_c;
    logic             alu_valid_c;
    logic [WIDTH-1:0] alu_res_c;
    logic             alu_acarry_c;
    logic             alu_lcarry_c;
    logic             alu_ovf_c;

    assign lhs_x = {1'b0, lhs_in};
    assign rhs_x = {1'b0, rhs_in};
    assign cin_x = XW'(flag_acarry);

    // Bus view of the result register follows assert_bus in the same cycle.
    assign bus_out = assert_bus ? result : '0;
    assign bus_en  = assert_bus;

    // Single-cycle ALU: next result and flag values for every non-MUL opcode.
    always_comb begin
        alu_valid_c  = 1'b1;
        alu_res_c    = lhs_in;
        alu_acarry_c = flag_acarry;
        alu_lcarry_c = 1'b0;
        alu_ovf_c    = 1'b0;
        wide_c       = '0;
        case (operation)
            OP_INC: begin
                wide_c       = lhs_x + XW'(1);
                alu_res_c    = wide_c[WIDTH-1:0];
                alu_acarry_c = wide_c[WIDTH];
                alu_ovf_c    = ~lhs_in[WIDTH-1] & alu_res_c[WIDTH-1];
            end
            OP_DEC: begin
                wide_c       = lhs_x - XW'(1);
                alu_res_c    = wide_c[WIDTH-1:0];
                alu_acarry_c = wide_c[WIDTH];
                alu_ovf_c    = lhs_in[WIDTH-1] & ~alu_res_c[WIDTH-1];
            end
            OP_ADD, OP_ADC: begin
                wide_c       = lhs_x + rhs_x + ((operation == OP_ADC) ? cin_x : XW'(0));
                alu_res_c    = wide_c[WIDTH-1:0];
                alu_acarry_c = wide_c[WIDTH];
                alu_ovf_c    = (lhs_in[WIDTH-1] == rhs_in[WIDTH-1]) &&
                               (alu_res_c[WIDTH-1] != lhs_in[WIDTH-1]);
            end
            OP_SUB, OP_SBC: begin
                // Top bit of the WIDTH+1 difference is the borrow-out.
                wide_c       = lhs_x - rhs_x - ((operation == OP_SBC) ? cin_x : XW'(0));
                alu_res_c    = wide_c[WIDTH-1:0];
                alu_acarry_c = wide_c[WIDTH];
                alu_ovf_c    = (lhs_in[WIDTH-1] != rhs_in[WIDTH-1]) &&
                               (alu_res_c[WIDTH-1] != lhs_in[WIDTH-1]);
            end
            OP_SHL: begin
                alu_res_c    = {lhs_in[WIDTH-2:0], 1'b0};
                alu_lcarry_c = lhs_in[WIDTH-1];
            end
            OP_SHR: begin
                alu_res_c    = {1'b0, lhs_in[WIDTH-1:1]};
                alu_lcarry_c = lhs_in[0];
            end
            OP_ROL: begin
                alu_res_c    = {lhs_in[WIDTH-2:0], lhs_in[WIDTH-1]};
                alu_lcarry_c = lhs_in[WIDTH-1];
            end
            OP_ROR: begin
                alu_res_c    = {lhs_in[0], lhs_in[WIDTH-1:1]};
                alu_lcarry_c = lhs_in[0];
            end
            OP_XOR:  alu_res_c = lhs_in ^ rhs_in;
            OP_AND:  alu_res_c = lhs_in & rhs_in;
            OP_OR:   alu_res_c = lhs_in | rhs_in;
            OP_NOT:  alu_res_c = ~lhs_in;
            default: alu_valid_c = 1'b0;
        endcase
    end

`ifdef ALU_MC_MUL_EN

    localparam logic [3:0]  OP_MUL = 4'hF;
    localparam int unsigned PW     = 2 * WIDTH;
    localparam int unsigned CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

    state_t           state;
    logic [PW-1:0]    mcand;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    acc_next_c;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    cnt;

    // One partial product per cycle: add the shifted multiplicand when the current multiplier bit is set.
    assign acc_next_c = acc + (mplier[0] ? mcand : '0);

    // Control FSM plus result/flag registers; the last MUL step writes the final product directly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            result        <= '0;
            result_hi     <= '0;
            flag_zero     <= 1'b0;
            flag_acarry   <= 1'b0;
            flag_lcarry   <= 1'b0;
            flag_sign     <= 1'b0;
            flag_overflow <= 1'b0;
            mcand         <= '0;
            acc           <= '0;
            mplier        <= '0;
            cnt           <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (alu_valid_c) begin
                        result        <= alu_res_c;
                        flag_zero     <= (alu_res_c == '0);
                        flag_acarry   <= alu_acarry_c;
                        flag_lcarry   <= alu_lcarry_c;
                        flag_sign     <= alu_res_c[WIDTH-1];
                        flag_overflow <= alu_ovf_c;
                        done          <= 1'b1;
                    end else if (operation == OP_MUL) begin
                        state  <= S_MUL;
                        busy   <= 1'b1;
                        mcand  <= PW'(lhs_in);
                        mplier <= rhs_in;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                S_MUL: begin
                    acc    <= acc_next_c;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state         <= S_IDLE;
                        busy          <= 1'b0;
                        done          <= 1'b1;
                        result        <= acc_next_c[WIDTH-1:0];
                        result_hi     <= acc_next_c[PW-1:WIDTH];
                        flag_zero     <= (acc_next_c == '0);
                        flag_acarry   <= (acc_next_c[PW-1:WIDTH] != '0);
                        flag_lcarry   <= 1'b0;
                        flag_sign     <= acc_next_c[PW-1];
                        flag_overflow <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`else

    assign busy      = 1'b0;
    assign result_hi = '0;

    // Result/flag registers; every valid opcode completes in the cycle it is sampled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done          <= 1'b0;
            result        <= '0;
            flag_zero     <= 1'b0;
            flag_acarry   <= 1'b0;
            flag_lcarry   <= 1'b0;
            flag_sign     <= 1'b0;
            flag_overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            if (alu_valid_c) begin
                result        <= alu_res_c;
                flag_zero     <= (alu_res_c == '0);
                flag_acarry   <= alu_acarry_c;
                flag_lcarry   <= alu_lcarry_c;
                flag_sign     <= alu_res_c[WIDTH-1];
                flag_overflow <= alu_ovf_c;
                done          <= 1'b1;
            end
        end
    end

`endif

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits (>=4).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 operation  input  4  opcode, sampled every rising edge; 0 = NOP.
REQ-005 lhs_in  input  WIDTH  left operand, sampled with operation.
REQ-006 rhs_in  input  WIDTH  right operand, sampled with operation.
REQ-007 assert_bus  input  1  drive result onto bus.
REQ-008 bus_out  output  WIDTH  result when assert_bus=1, else 0 (combinational).
REQ-009 bus_en  output  1  equals assert_bus (combinational).
REQ-010 result_hi  output  WIDTH  registered upper half of MUL product.
REQ-011 busy  output  1  multi-cycle op in progress.
REQ-012 done  output  1  one-cycle pulse: result and flags just updated.
REQ-013 flag_zero, flag_acarry, flag_lcarry, flag_sign, flag_overflow  output  1 each  registered status flags.

Function
REQ-014 Opcodes: 1 INC, 2 DEC, 3 ADD, 4 ADC, 5 SHL, 6 SHR, 7 SUB, 8 SBC, 9 XOR, A AND, B OR, C NOT(lhs), D ROL, E ROR, F MUL.
REQ-015 Non-NOP opcode other than MUL, with busy=0, at edge N: result, flags, done=1 registered at edge N; done clears at N+1 unless another op issues.
REQ-016 NOP: result, result_hi, flags held; done=0.
REQ-017 ADC adds registered flag_acarry; SBC subtracts registered flag_acarry (borrow).
REQ-018 flag_acarry: carry-out for INC/ADD/ADC; borrow-out (1 when minuend < subtrahend+borrow) for DEC/SUB/SBC; held for logic/shift/rotate ops.
REQ-019 flag_lcarry: bit shifted/rotated out for SHL/SHR/ROL/ROR; 0 for all other ops.
REQ-020 flag_overflow: two's-complement overflow for INC/DEC/ADD/ADC/SUB/SBC; 0 otherwise.
REQ-021 flag_zero = (result==0), flag_sign = result[WIDTH-1], for every non-MUL op.
REQ-022 SHL/SHR shift in 0; ROL/ROR rotate by one bit within WIDTH.
REQ-023 Arithmetic internally WIDTH+1 bits; result truncated to WIDTH.
REQ-024 States IDLE and MUL; IDLE->MUL on opcode F at edge N (operands latched, busy=1); MUL->IDLE at edge N+WIDTH (busy=0, done=1, result/result_hi/flags written).
REQ-025 MUL: unsigned shift-add, one partial product per cycle, 2*WIDTH-bit product; result=low half, result_hi=high half.
REQ-026 MUL flags: zero = full product ==0; acarry = (result_hi!=0); sign = result_hi[WIDTH-1]; lcarry=0; overflow=0.
REQ-027 While busy=1, operation/lhs_in/rhs_in are ignored; outputs hold previous values until completion.
REQ-028 Non-MUL ops leave result_hi unchanged.
REQ-029 bus_out/bus_en follow assert_bus in the same cycle, including while busy (shows previous result).

Reset
REQ-030 reset_n=0 forces, asynchronously: result=0, result_hi=0, all flags=0, busy=0, done=0, state IDLE.
REQ-031 Reset during MUL aborts it; no done pulse is produced for the aborted op.
REQ-032 First opcode is sampled at the first rising edge with reset_n=1.

Configuration
REQ-033 Macro ALU_MC_MUL_EN defined: opcode F is MUL per REQ-024..026.
REQ-034 Macro ALU_MC_MUL_EN undefined: opcode F behaves as NOP, busy is constant 0, result_hi is constant 0, no multiplier logic.

Verification (WIDTH=8)
REQ-035 AND lhs=0x55 rhs=0xAA -> result 0x00, zero=1, lcarry=0, done pulse 1 cycle; OR same operands -> 0xFF, sign=1, zero=0.
REQ-036 ADD 200+64 -> result 0x08, acarry=1, overflow=0; then ADC 0+0 -> 0x01, acarry=0; then ADC 0+0 -> 0x00, zero=1.
REQ-037 SUB 0x01-0x81 -> result 0x80, acarry(borrow)=1, sign=1, overflow=1; SHR 0x01 -> 0x00, lcarry=1, zero=1.
REQ-038 MUL 0xFF*0xFF (ALU_MC_MUL_EN) -> busy high 8 cycles, ops issued meanwhile ignored, done at edge N+8 with result 0x01, result_hi 0xFE, acarry=1, sign=1.
REQ-039 reset_n low 3 cycles into MUL -> all outputs 0 immediately, busy=0, no done; next ADD 1+1 -> 0x02 normally.
REQ-040 assert_bus=0 -> bus_out 0x00, bus_en 0; assert_bus=1 -> bus_out equals result same cycle.
